// File: rtl/sim_dram_arb_pkg.sv
// Shared types and the round-robin pick helper for the sim_dram port arbiter.
package sim_dram_arb_pkg;

    localparam int unsigned MaxPorts = 32;
    localparam int unsigned PickIdxW = $clog2(MaxPorts);

    typedef struct packed {
        logic                found;
        logic [PickIdxW-1:0] idx;
    } pick_t;

    // Index width for n requesters; a single requester still needs one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // First set bit of req at or after ptr, wrapping within the low n bits.
    function automatic pick_t rr_pick(input logic [MaxPorts-1:0] req,
                                      input logic [PickIdxW-1:0] ptr,
                                      input int unsigned         n);
        pick_t             res;
        logic [PickIdxW:0] j;
        res = '0;
        for (int unsigned i = 0; i < MaxPorts; i++) begin
            if (i < n) begin
                j = {1'b0, ptr} + (PickIdxW+1)'(i);
                if (j >= (PickIdxW+1)'(n)) begin
                    j = j - (PickIdxW+1)'(n);
                end
                if (!res.found && req[j[PickIdxW-1:0]]) begin
                    res.found = 1'b1;
                    res.idx   = j[PickIdxW-1:0];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sim_dram_arb_id_fifo.sv
// In-order ring buffer of requester indices; occupancy doubles as the inflight count.
module sim_dram_arb_id_fifo #(
    parameter int unsigned Depth = 8,
    parameter type         idx_t = logic
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  idx_t                     data,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output idx_t                     head,
    output logic [$clog2(Depth):0]   count
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth) + 1;

    idx_t            mem [Depth];
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;

    assign full  = (count == CntW'(Depth));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PtrW'(Depth - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PtrW'(Depth - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once pushed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data;
        end
    end

    a_no_overflow:  assert property (@(posedge clk) disable iff (rst) !(push && full));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(pop && empty));

endmodule

// File: rtl/sim_dram_arb.sv
// Round-robin arbiter sharing one sim_dram port; responses routed back in issue order.
module sim_dram_arb
    import sim_dram_arb_pkg::*;
#(
    parameter int unsigned NumPorts  = 2,
    parameter int unsigned DataWidth = 512,
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned MaxReads  = 8,
    parameter int unsigned MaxWrites = 8
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NumPorts-1:0]             s_req_valid_i,
    output logic [NumPorts-1:0]             s_req_ready_o,
    input  logic [NumPorts-1:0]             s_we_i,
    input  logic [NumPorts*AddrWidth-1:0]   s_addr_i,
    input  logic [NumPorts*DataWidth-1:0]   s_wdata_i,
    input  logic [NumPorts*DataWidth/8-1:0] s_wstrb_i,
    output logic [NumPorts-1:0]             s_rsp_valid_o,
    input  logic [NumPorts-1:0]             s_rsp_ready_i,
    output logic [DataWidth-1:0]            s_rdata_o,
    output logic [NumPorts-1:0]             s_b_valid_o,
    input  logic [NumPorts-1:0]             s_b_ready_i,
    output logic                            m_req_valid_o,
    input  logic                            m_req_ready_i,
    output logic                            m_we_o,
    output logic [AddrWidth-1:0]            m_addr_o,
    output logic [DataWidth-1:0]            m_wdata_o,
    output logic [DataWidth/8-1:0]          m_wstrb_o,
    input  logic                            m_rsp_valid_i,
    output logic                            m_rsp_ready_o,
    input  logic [DataWidth-1:0]            m_rdata_i,
    input  logic                            m_b_valid_i,
    output logic                            m_b_ready_o,
    output logic [$clog2(MaxReads):0]       rd_inflight_o,
    output logic [$clog2(MaxWrites):0]      wr_inflight_o
);

    localparam int unsigned IdxW      = idx_width(NumPorts);
    localparam int unsigned StrbWidth = DataWidth / 8;

    typedef logic [IdxW-1:0] port_idx_t;

    port_idx_t           rr_ptr;
    port_idx_t           win;
    pick_t               pick;
    logic [NumPorts-1:0] elig;
    logic                req_hs;
    logic                rd_push, rd_pop, rd_full, rd_empty;
    logic                wr_push, wr_pop, wr_full, wr_empty;
    port_idx_t           rd_head, wr_head;

    // A full ID FIFO blocks its request type outright; no same-cycle pop bypass.
    always_comb begin
        for (int p = 0; p < NumPorts; p++) begin
            elig[p] = s_req_valid_i[p] & (s_we_i[p] ? ~wr_full : ~rd_full);
        end
        pick = rr_pick(MaxPorts'(elig), PickIdxW'(rr_ptr), NumPorts);
        win  = port_idx_t'(pick.idx);
    end

    always_comb begin
        m_req_valid_o = pick.found & ~rst_i;
        m_we_o        = 1'b0;
        m_addr_o      = '0;
        m_wdata_o     = '0;
        m_wstrb_o     = '0;
        s_req_ready_o = '0;
        for (int p = 0; p < NumPorts; p++) begin
            if (port_idx_t'(p) == win) begin
                m_we_o           = s_we_i[p];
                m_addr_o         = s_addr_i[p*AddrWidth +: AddrWidth];
                m_wdata_o        = s_wdata_i[p*DataWidth +: DataWidth];
                m_wstrb_o        = s_wstrb_i[p*StrbWidth +: StrbWidth];
                s_req_ready_o[p] = pick.found & m_req_ready_i & ~rst_i;
            end
        end
    end

    assign req_hs  = m_req_valid_o & m_req_ready_i;
    assign rd_push = req_hs & ~m_we_o;
    assign wr_push = req_hs & m_we_o;

    // Pointer moves past the winner only on a handshake, so a stalled winner keeps the grant.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr <= '0;
        end else if (req_hs) begin
            rr_ptr <= (win == port_idx_t'(NumPorts - 1)) ? '0 : win + 1'b1;
        end
    end

    // Responses go to the FIFO head; an empty FIFO drains stray beats.
    always_comb begin
        s_rsp_valid_o = '0;
        s_b_valid_o   = '0;
        m_rsp_ready_o = 1'b0;
        m_b_ready_o   = 1'b0;
        if (!rst_i) begin
            m_rsp_ready_o = rd_empty;
            m_b_ready_o   = wr_empty;
            for (int p = 0; p < NumPorts; p++) begin
                if (!rd_empty && rd_head == port_idx_t'(p)) begin
                    s_rsp_valid_o[p] = m_rsp_valid_i;
                    m_rsp_ready_o    = s_rsp_ready_i[p];
                end
                if (!wr_empty && wr_head == port_idx_t'(p)) begin
                    s_b_valid_o[p] = m_b_valid_i;
                    m_b_ready_o    = s_b_ready_i[p];
                end
            end
        end
    end

    assign s_rdata_o = m_rdata_i;
    assign rd_pop    = m_rsp_valid_i & m_rsp_ready_o & ~rd_empty;
    assign wr_pop    = m_b_valid_i & m_b_ready_o & ~wr_empty;

    sim_dram_arb_id_fifo #(.Depth(MaxReads), .idx_t(port_idx_t)) i_rd_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (rd_push),
        .data  (win),
        .pop   (rd_pop),
        .full  (rd_full),
        .empty (rd_empty),
        .head  (rd_head),
        .count (rd_inflight_o)
    );

    sim_dram_arb_id_fifo #(.Depth(MaxWrites), .idx_t(port_idx_t)) i_wr_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (wr_push),
        .data  (win),
        .pop   (wr_pop),
        .full  (wr_full),
        .empty (wr_empty),
        .head  (wr_head),
        .count (wr_inflight_o)
    );

    a_rsp_has_owner: assert property (@(posedge clk_i) disable iff (rst_i) !(m_rsp_valid_i && rd_empty));
    a_b_has_owner:   assert property (@(posedge clk_i) disable iff (rst_i) !(m_b_valid_i && wr_empty));

endmodule

// File: tb/tb_sim_dram_arb.sv
// Directed bench for sim_dram_arb with a small in-order DRAM model and response logs.
module tb_sim_dram_arb;

    localparam int unsigned NP = 2;
    localparam int unsigned DW = 64;
    localparam int unsigned AW = 32;
    localparam int unsigned SW = DW / 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NP-1:0]     s_req_valid_i, s_req_ready_o, s_we_i;
    logic [NP*AW-1:0]  s_addr_i;
    logic [NP*DW-1:0]  s_wdata_i;
    logic [NP*SW-1:0]  s_wstrb_i;
    logic [NP-1:0]     s_rsp_valid_o, s_rsp_ready_i, s_b_valid_o, s_b_ready_i;
    logic [DW-1:0]     s_rdata_o;
    logic              m_req_valid_o, m_req_ready_i, m_we_o;
    logic [AW-1:0]     m_addr_o;
    logic [DW-1:0]     m_wdata_o, m_rdata_i;
    logic [SW-1:0]     m_wstrb_o;
    logic              m_rsp_valid_i, m_rsp_ready_o, m_b_valid_i, m_b_ready_o;
    logic [2:0]        rd_inflight_o, wr_inflight_o;

    sim_dram_arb #(.NumPorts(NP), .DataWidth(DW), .AddrWidth(AW), .MaxReads(4), .MaxWrites(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .s_req_valid_i(s_req_valid_i), .s_req_ready_o(s_req_ready_o), .s_we_i(s_we_i),
        .s_addr_i(s_addr_i), .s_wdata_i(s_wdata_i), .s_wstrb_i(s_wstrb_i),
        .s_rsp_valid_o(s_rsp_valid_o), .s_rsp_ready_i(s_rsp_ready_i), .s_rdata_o(s_rdata_o),
        .s_b_valid_o(s_b_valid_o), .s_b_ready_i(s_b_ready_i),
        .m_req_valid_o(m_req_valid_o), .m_req_ready_i(m_req_ready_i), .m_we_o(m_we_o),
        .m_addr_o(m_addr_o), .m_wdata_o(m_wdata_o), .m_wstrb_o(m_wstrb_o),
        .m_rsp_valid_i(m_rsp_valid_i), .m_rsp_ready_o(m_rsp_ready_o), .m_rdata_i(m_rdata_i),
        .m_b_valid_i(m_b_valid_i), .m_b_ready_o(m_b_ready_o),
        .rd_inflight_o(rd_inflight_o), .wr_inflight_o(wr_inflight_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] init_word(input int i);
        return {16'hD0D0, 16'(i), 16'hC0DE, 16'(i)};
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wd,
                                          input logic [7:0] st);
        logic [63:0] r;
        r = old;
        for (int b = 0; b < 8; b++) if (st[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        return r;
    endfunction

    // In-order DRAM model: reads answer from a queue, writes produce one ack each.
    logic [63:0] mem [128];
    logic [63:0] rq  [256];
    logic [7:0]  rq_wr, rq_rd;
    int          b_cnt;
    logic        rsp_hold, b_hold;

    assign m_rsp_valid_i = (rq_wr != rq_rd) && !rsp_hold;
    assign m_rdata_i     = rq[rq_rd];
    assign m_b_valid_i   = (b_cnt != 0) && !b_hold;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 128; i++) mem[i] <= init_word(i);
            rq_wr <= 8'd0;
            rq_rd <= 8'd0;
            b_cnt <= 0;
        end else begin
            if (m_req_valid_o && m_req_ready_i) begin
                if (m_we_o) mem[m_addr_o[9:3]] <= merge(mem[m_addr_o[9:3]], m_wdata_o, m_wstrb_o);
                else begin
                    rq[rq_wr] <= mem[m_addr_o[9:3]];
                    rq_wr     <= rq_wr + 8'd1;
                end
            end
            if (m_rsp_valid_i && m_rsp_ready_o) rq_rd <= rq_rd + 8'd1;
            b_cnt <= b_cnt + ((m_req_valid_o && m_req_ready_i && m_we_o) ? 1 : 0)
                           - ((m_b_valid_i && m_b_ready_o) ? 1 : 0);
        end
    end

    // Handshake logs; inputs only change just after posedge, so negedge values hold at the edge.
    int          glog[$];
    int          rport[$];
    logic [63:0] rdata[$];
    int          bport[$];

    always @(negedge clk) begin
        if (!rst) begin
            for (int p = 0; p < NP; p++) begin
                if (s_req_valid_i[p] && s_req_ready_o[p]) glog.push_back(p);
                if (s_rsp_valid_o[p] && s_rsp_ready_i[p]) begin
                    rport.push_back(p);
                    rdata.push_back(s_rdata_o);
                end
                if (s_b_valid_o[p] && s_b_ready_i[p]) bport.push_back(p);
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        glog.delete(); rport.delete(); rdata.delete(); bport.delete();
    endtask

    task automatic set_port(input int p, input logic v, input logic we, input logic [31:0] a,
                            input logic [63:0] wd, input logic [7:0] st);
        s_req_valid_i[p]       = v;
        s_we_i[p]              = we;
        s_addr_i[p*AW +: AW]   = a;
        s_wdata_i[p*DW +: DW]  = wd;
        s_wstrb_i[p*SW +: SW]  = st;
    endtask

    task automatic rand_ready();
        m_req_ready_i    = 1'($urandom_range(0, 1));
        s_rsp_ready_i[0] = 1'($urandom_range(0, 1));
        s_b_ready_i[0]   = 1'($urandom_range(0, 1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [63:0] exp_q[$];
    logic [63:0] shadow [128];
    logic [63:0] e;
    logic        g, ok;

    initial begin
        rst = 1'b1;
        s_req_valid_i = '0; s_we_i = '0; s_addr_i = '0; s_wdata_i = '0; s_wstrb_i = '0;
        s_rsp_ready_i = '1; s_b_ready_i = '1; m_req_ready_i = 1'b1;
        rsp_hold = 1'b0; b_hold = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        // Reset: requests present but every valid/ready held low
        s_req_valid_i = 2'b11;
        #1;
        check_eq("rst_m_req_valid", 64'(m_req_valid_o), 64'd0);
        check_eq("rst_s_req_ready", 64'(s_req_ready_o), 64'd0);
        check_eq("rst_m_rsp_ready", 64'(m_rsp_ready_o), 64'd0);
        check_eq("rst_rd_inflight", 64'(rd_inflight_o), 64'd0);
        check_eq("rst_wr_inflight", 64'(wr_inflight_o), 64'd0);
        s_req_valid_i = '0;
        cycle();
        rst = 1'b0;
        cycle();

        // 1: both ports read every cycle -> alternating grants, in-order data
        clear_logs();
        set_port(0, 1'b1, 1'b0, 32'h0000_0000, '0, '0);
        set_port(1, 1'b1, 1'b0, 32'h0000_0008, '0, '0);
        repeat (6) cycle();
        set_port(0, 1'b0, 1'b0, 32'h0, '0, '0);
        set_port(1, 1'b0, 1'b0, 32'h0, '0, '0);
        repeat (5) cycle();
        check_eq("t1_grant_cnt", 64'(glog.size()), 64'd6);
        check_eq("t1_rsp_cnt", 64'(rport.size()), 64'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < glog.size()) check_eq($sformatf("t1_grant%0d", i), 64'(glog[i]), 64'(i % 2));
            if (i < rport.size()) begin
                check_eq($sformatf("t1_rport%0d", i), 64'(rport[i]), 64'(i % 2));
                check_eq($sformatf("t1_rdata%0d", i), rdata[i], init_word(i % 2));
            end
        end
        check_eq("t1_rd_inflight", 64'(rd_inflight_o), 64'd0);

        // 2: port 1 partial write, then port 0 reads it back
        clear_logs();
        set_port(1, 1'b1, 1'b1, 32'h8000_0040, 64'h1122_3344_5566_7788, 8'h0F);
        #1;
        check_eq("t2_wr_grant", 64'(s_req_ready_o), 64'b10);
        check_eq("t2_m_addr", 64'(m_addr_o), 64'h8000_0040);
        cycle();
        set_port(1, 1'b0, 1'b0, 32'h0, '0, '0);
        repeat (2) cycle();
        set_port(0, 1'b1, 1'b0, 32'h8000_0040, '0, '0);
        cycle();
        set_port(0, 1'b0, 1'b0, 32'h0, '0, '0);
        repeat (4) cycle();
        e = init_word(8);
        e[31:0] = 32'h5566_7788;
        check_eq("t2_b_cnt", 64'(bport.size()), 64'd1);
        if (bport.size() > 0) check_eq("t2_b_port", 64'(bport[0]), 64'd1);
        check_eq("t2_rsp_cnt", 64'(rport.size()), 64'd1);
        if (rport.size() > 0) begin
            check_eq("t2_rport", 64'(rport[0]), 64'd0);
            check_eq("t2_rdata", rdata[0], e);
        end

        // 3: read FIFO full stalls port 0 reads, port 1 write still granted
        clear_logs();
        rsp_hold = 1'b1;
        set_port(0, 1'b1, 1'b0, 32'h0000_0010, '0, '0);
        repeat (6) cycle();
        check_eq("t3_grants", 64'(glog.size()), 64'd4);
        check_eq("t3_stall", 64'(s_req_ready_o), 64'd0);
        check_eq("t3_rd_inflight", 64'(rd_inflight_o), 64'd4);
        set_port(1, 1'b1, 1'b1, 32'h0000_0048, 64'hFFFF_0000_FFFF_0000, 8'hFF);
        #1;
        check_eq("t3_wr_grant", 64'(s_req_ready_o), 64'b10);
        check_eq("t3_m_we", 64'(m_we_o), 64'd1);
        cycle();
        set_port(1, 1'b0, 1'b0, 32'h0, '0, '0);
        repeat (3) cycle();
        check_eq("t3_b_cnt", 64'(bport.size()), 64'd1);
        check_eq("t3_wr_inflight", 64'(wr_inflight_o), 64'd0);
        set_port(0, 1'b0, 1'b0, 32'h0, '0, '0);
        rsp_hold = 1'b0;
        repeat (8) cycle();
        check_eq("t3_rsp_cnt", 64'(rport.size()), 64'd4);
        for (int i = 0; i < rport.size(); i++) begin
            check_eq($sformatf("t3_rport%0d", i), 64'(rport[i]), 64'd0);
            check_eq($sformatf("t3_rdata%0d", i), rdata[i], init_word(2));
        end
        check_eq("t3_rd_inflight_end", 64'(rd_inflight_o), 64'd0);

        // 4: port 0 back-pressures its response, port 1 waits behind it
        clear_logs();
        s_rsp_ready_i = 2'b10;
        set_port(0, 1'b1, 1'b0, 32'h0000_0018, '0, '0);
        cycle();
        set_port(0, 1'b0, 1'b0, 32'h0, '0, '0);
        set_port(1, 1'b1, 1'b0, 32'h0000_0020, '0, '0);
        cycle();
        set_port(1, 1'b0, 1'b0, 32'h0, '0, '0);
        repeat (10) cycle();
        check_eq("t4_blocked", 64'(rport.size()), 64'd0);
        check_eq("t4_rsp_valid", 64'(s_rsp_valid_o), 64'b01);
        check_eq("t4_m_rsp_ready", 64'(m_rsp_ready_o), 64'd0);
        check_eq("t4_rd_inflight", 64'(rd_inflight_o), 64'd2);
        s_rsp_ready_i = 2'b11;
        repeat (5) cycle();
        check_eq("t4_rsp_cnt", 64'(rport.size()), 64'd2);
        if (rport.size() == 2) begin
            check_eq("t4_rport0", 64'(rport[0]), 64'd0);
            check_eq("t4_rdata0", rdata[0], init_word(3));
            check_eq("t4_rport1", 64'(rport[1]), 64'd1);
            check_eq("t4_rdata1", rdata[1], init_word(4));
        end

        // 5: reset with three reads outstanding
        clear_logs();
        rsp_hold = 1'b1;
        set_port(0, 1'b1, 1'b0, 32'h0000_0028, '0, '0);
        repeat (3) cycle();
        set_port(0, 1'b0, 1'b0, 32'h0, '0, '0);
        #1;
        check_eq("t5_rd_inflight_pre", 64'(rd_inflight_o), 64'd3);
        rsp_hold = 1'b0;
        s_req_valid_i = 2'b11;
        rst = 1'b1;
        #1;
        check_eq("t5_rst_m_req_valid", 64'(m_req_valid_o), 64'd0);
        check_eq("t5_rst_s_req_ready", 64'(s_req_ready_o), 64'd0);
        check_eq("t5_rst_rsp_valid", 64'(s_rsp_valid_o), 64'd0);
        check_eq("t5_rst_rd_inflight", 64'(rd_inflight_o), 64'd0);
        cycle();
        cycle();
        s_req_valid_i = '0;
        rst = 1'b0;
        repeat (5) cycle();
        check_eq("t5_no_stray", 64'(rport.size()), 64'd0);
        set_port(1, 1'b1, 1'b0, 32'h0000_0030, '0, '0);
        #1;
        check_eq("t5_post_grant", 64'(s_req_ready_o), 64'b10);
        cycle();
        set_port(1, 1'b0, 1'b0, 32'h0, '0, '0);
        repeat (5) cycle();
        check_eq("t5_rsp_cnt", 64'(rport.size()), 64'd1);
        if (rport.size() == 1) begin
            check_eq("t5_rport", 64'(rport[0]), 64'd1);
            check_eq("t5_rdata", rdata[0], init_word(6));
        end

        // 6: single port mixed traffic under random back-pressure
        clear_logs();
        exp_q.delete();
        for (int i = 0; i < 128; i++) shadow[i] = init_word(i);
        for (int k = 0; k < 18; k++) begin
            logic        we;
            logic [31:0] a;
            logic [63:0] wd;
            logic [7:0]  st;
            we = (k % 3 == 0);
            a  = 32'(32 + (k % 4)) << 3;
            wd = {32'(k) * 32'h0101_0101, ~32'(k)};
            st = 8'hFF >> (k % 4);
            set_port(0, 1'b1, we, a, wd, st);
            ok = 1'b0;
            for (int t = 0; t < 64 && !ok; t++) begin
                rand_ready();
                #1;
                g = s_req_ready_o[0];
                cycle();
                ok = g;
            end
            if (!ok) begin
                check_eq($sformatf("t6_grant_timeout%0d", k), 64'd0, 64'd1);
            end else if (we) begin
                shadow[a[9:3]] = merge(shadow[a[9:3]], wd, st);
            end else begin
                exp_q.push_back(shadow[a[9:3]]);
            end
        end
        set_port(0, 1'b0, 1'b0, 32'h0, '0, '0);
        repeat (40) begin
            rand_ready();
            cycle();
        end
        m_req_ready_i = 1'b1;
        s_rsp_ready_i = 2'b11;
        s_b_ready_i   = 2'b11;
        repeat (10) cycle();
        check_eq("t6_rd_inflight", 64'(rd_inflight_o), 64'd0);
        check_eq("t6_wr_inflight", 64'(wr_inflight_o), 64'd0);
        check_eq("t6_rsp_cnt", 64'(rport.size()), 64'(exp_q.size()));
        check_eq("t6_b_cnt", 64'(bport.size()), 64'd6);
        for (int i = 0; i < exp_q.size() && i < rport.size(); i++) begin
            check_eq($sformatf("t6_rport%0d", i), 64'(rport[i]), 64'd0);
            check_eq($sformatf("t6_rdata%0d", i), rdata[i], exp_q[i]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
